// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Iterative double-dabble converter: turns a W-bit unsigned binary value
//   into D packed BCD digits, one input bit per clock. Sits behind the 8x8
//   multiplier so the seven-segment display shows the product in decimal.
//
// Ports
//   clk    : system clock, rising edge active
//   reset  : synchronous, active-high reset
//   start  : conversion request, only looked at while idle
//   bin    : W-bit binary operand, captured on the accepting edge
//   busy   : high while a conversion is in progress
//   done   : one-cycle pulse on the edge bcd/blank are updated
//   bcd    : D packed digits, digit 0 (units) in bcd[3:0]
//   blank  : leading-zero mask, bit i set when digit i and all above are 0
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start, bcd/blank hold the last result
//   S_SHIFT | add-3 then shift one bit per clock, W clocks total
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int W = 16,
    parameter int D = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic [D-1:0]     blank
);

    // Number of decimal digits needed for the largest W-bit value.
    function automatic int dec_digits(input int w);
        longint unsigned v;
        longint unsigned one;
        int n;
        one = 1;
        v   = (one << w) - one;
        n   = 0;
        while (v != 0) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    if (D < dec_digits(W)) begin : g_bad_digits
        $error("bin_to_bcd_seq: D=%0d digits cannot hold a %0d-bit value", D, W);
    end

    localparam int            CW        = $clog2(W + 1);
    localparam int            SW        = 4 * D;
    localparam logic [CW-1:0] LAST      = CW'(W - 1);
    localparam logic [D-1:0]  BLANK_RST = {{(D-1){1'b1}}, 1'b0};

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [SW-1:0]   scratch_q, scratch_d;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic [D-1:0]    blank_q, blank_d;
    logic            done_q, done_d;

    logic [SW-1:0]   adj;
    logic [SW+W-1:0] shifted;
    logic [D-1:0]    blank_new;
    logic            zero_run;

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. The final shift happens on the edge that moves the
    // counter from W-1 to W.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)         state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == LAST) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Add 3 to every digit >= 5, then shift {scratch, shreg} left by one.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < D; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        shifted = {adj[SW-2:0], shreg_q, 1'b0};
    end

    // Leading-zero mask of the post-shift scratch; digit 0 is never blanked.
    always_comb begin
        zero_run  = 1'b1;
        blank_new = '0;
        for (int i = D - 1; i >= 1; i--) begin
            zero_run     = zero_run & (shifted[W + 4*i +: 4] == 4'd0);
            blank_new[i] = zero_run;
        end
    end

    // Datapath next values.
    always_comb begin
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                end
            end
            S_SHIFT: begin
                scratch_d = shifted[SW+W-1:W];
                shreg_d   = shifted[W-1:0];
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bcd_d   = shifted[SW+W-1:W];
                    blank_d = blank_new;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output logic.
    always_comb begin
        busy  = (state_q == S_SHIFT);
        done  = done_q;
        bcd   = bcd_q;
        blank = blank_q;
    end

    // The add-3 correction keeps every scratch digit a legal BCD value.
    for (genvar gi = 0; gi < D; gi++) begin : g_digit_chk
        a_digit_le9: assert property (@(posedge clk) disable iff (reset)
                                      scratch_q[4*gi +: 4] <= 4'd9);
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Directed and randomized bench for bin_to_bcd_seq. Expected digits come
//   from integer division by powers of ten; expected blanking from comparing
//   the value against powers of ten.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int W = 16;
    localparam int D = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  bin;
    logic          busy;
    logic          done;
    logic [4*D-1:0] bcd;
    logic [D-1:0]  blank;

    int n_checks = 0;
    int n_pass   = 0;

    bin_to_bcd_seq #(.W(W), .D(D)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    always #5 clk = ~clk;

    function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
        int unsigned p;
        logic [4*D-1:0] r;
        p = 1;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] ref_blank(input int unsigned v);
        int unsigned p;
        logic [D-1:0] r;
        p = 1;
        r = '0;
        for (int i = 1; i < D; i++) begin
            p = p * 10;
            r[i] = (v < p);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full conversion; bin is scrambled while the converter is busy.
    task automatic run_conv(input logic [W-1:0] v, input string tag);
        int lat;
        int busy_cyc;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cyc++;
            bin = W'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 16);
        chk({tag, "_busy_cycles"}, busy_cyc, 16);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, ref_bcd(v)});
        chk({tag, "_blank"}, {27'd0, blank}, {27'd0, ref_blank(v)});
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, done}, 0);
        chk({tag, "_bcd_hold"}, {12'd0, bcd}, {12'd0, ref_bcd(v)});
    endtask

    initial begin
        int lat;
        int dones;
        int last_done;
        int spacing_bad;
        logic [W-1:0] expq[$];
        logic [W-1:0] ev;

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        repeat (20) begin
            @(negedge clk);
            chk("idle_bcd", {12'd0, bcd}, 32'h0);
            chk("idle_blank", {27'd0, blank}, 32'b11110);
            chk("idle_busy", {31'd0, busy}, 0);
            chk("idle_done", {31'd0, done}, 0);
        end

        // Start on a reset edge must be ignored.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        bin   = 16'h1111;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("start_on_reset_busy", {31'd0, busy}, 0);

        // Directed values.
        run_conv(16'hFE01, "fe01");
        run_conv(16'hFFFF, "ffff");
        run_conv(16'd9,    "nine");
        run_conv(16'd1000, "thousand");
        run_conv(16'd0,    "zero");

        // Random values.
        repeat (6) run_conv(W'($urandom), "rand");

        // Second start during a conversion is ignored.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        bin   = 16'hFFFF;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_latency", lat, 16);
        chk("ignore_bcd", {12'd0, bcd}, 32'h04660);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("ignore_no_second_done", dones, 0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_bcd", {12'd0, bcd}, 32'h0);
        chk("abort_blank", {27'd0, blank}, 32'b11110);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_conv(16'd42, "after_abort");

        // Start held high, bin stepping every cycle. Accepts fall on edges
        // 0, 17, 34, ... of this loop while start is high.
        dones       = 0;
        last_done   = -1;
        spacing_bad = 0;
        for (int c = 0; c <= 340; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (last_done >= 0 && (c - 1) - last_done != 17) spacing_bad++;
                last_done = c - 1;
                if (expq.size() > 0) begin
                    ev = expq.pop_front();
                    chk("held_bcd", {12'd0, bcd}, {12'd0, ref_bcd(ev)});
                    chk("held_blank", {27'd0, blank}, {27'd0, ref_blank(ev)});
                end else begin
                    chk("held_unexpected_done", 32'd1, 32'd0);
                end
            end
            start = (c <= 300);
            bin   = W'(c);
            if (c <= 300 && c % 17 == 0) expq.push_back(W'(c));
        end
        start = 1'b0;
        chk("held_done_count", dones, 18);
        chk("held_spacing", spacing_bad, 0);
        chk("held_queue_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
